divide_by_50_clock_divider: RTL and testbench

- Synchronous clock divider: derives a square wave at 1/50 of the input clock frequency, 50% duty cycle.
- Used to generate slow timing/enable clocks from the board clock.
- Output is a registered signal, so it is glitch-free.
- Single clock domain; asynchronous active-low reset forces a known phase.

---
 rtl/divide_by_50_clock_divider.sv | 40 ++++
 tb/tb_divide_by_50_clock_divider.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/divide_by_50_clock_divider.sv
// Registered divide-by-DIVISOR square-wave generator with exact 50% duty cycle.
// Latency: the output toggles on the edge where the half-period counter wraps. There is no backpressure.
module divide_by_50_clock_divider #(
  parameter int DIVISOR = 50
) (
  input  logic CLK_IN,
  input  logic n_RST,
  output logic CLK_OUT
);

  localparam int HALF  = DIVISOR / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

  if (DIVISOR < 2 || (DIVISOR % 2) != 0) begin : g_bad_divisor
    $error("DIVISOR must be even and >= 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             w_term;

  // Out-of-range counts are not terminal, so they roll over through zero.
  assign w_term = (r_cnt == TERM);

  always_ff @(posedge CLK_IN or negedge n_RST) begin
    if (!n_RST) begin
      r_cnt <= '0;
      r_out <= 1'b1;
    end else if (w_term) begin
      r_cnt <= '0;
      r_out <= ~r_out;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign CLK_OUT = r_out;

endmodule

// File: tb/tb_divide_by_50_clock_divider.sv
// Bench for the divide-by-50 divider: fixed waveform vectors, reset corner cases, and randomized reset/run mixes.
`timescale 1ns/1ps
module tb_divide_by_50_clock_divider;

  localparam int DIV  = 50;
  localparam int HALF = DIV / 2;

  logic CLK_IN = 1'b0;
  logic n_RST  = 1'b1;
  logic CLK_OUT;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  divide_by_50_clock_divider #(.DIVISOR(DIV)) dut (
    .CLK_IN (CLK_IN),
    .n_RST  (n_RST),
    .CLK_OUT(CLK_OUT)
  );

  always #500 CLK_IN = ~CLK_IN;

  typedef struct {
    int   edge_no;
    logic exp_out;
  } vec_t;

  vec_t vecs[10];

  // Output after k rising edges since release: high for the first HALF edges' worth, then alternating.
  function automatic logic model_out(int k);
    return ((k / HALF) % 2) == 0;
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: CLK_OUT=%b expected %b (edges since release=%0d, t=%0t)",
               name, act, exp, edges, $time);
    end
  endtask

  task automatic run_edges(int n, string name);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_IN);
      edges++;
      @(negedge CLK_IN);
      check(name, CLK_OUT, model_out(edges));
    end
  endtask

  // Called just after a falling edge; asserts reset offset ns later, holds it across hold rising edges.
  task automatic do_reset(int offset, int hold);
    #(offset);
    n_RST = 1'b0;
    #1;
    check("rst_async_assert", CLK_OUT, 1'b1);
    edges = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK_IN);
      @(negedge CLK_IN);
      check("rst_held", CLK_OUT, 1'b1);
    end
    #10;
    n_RST = 1'b1;
    #1;
    check("rst_release", CLK_OUT, 1'b1);
  endtask

  initial begin
    int   run_len;
    logic prev;

    vecs[0] = '{24, 1'b1};
    vecs[1] = '{25, 1'b0};
    vecs[2] = '{26, 1'b0};
    vecs[3] = '{49, 1'b0};
    vecs[4] = '{50, 1'b1};
    vecs[5] = '{51, 1'b1};
    vecs[6] = '{74, 1'b1};
    vecs[7] = '{75, 1'b0};
    vecs[8] = '{99, 1'b0};
    vecs[9] = '{100, 1'b1};

    // Initial reset pulse while CLK_IN is low.
    #200;
    n_RST = 1'b0;
    #1;
    check("reset_during", CLK_OUT, 1'b1);
    #99;
    n_RST = 1'b1;
    #1;
    check("reset_after_release", CLK_OUT, 1'b1);
    edges = 0;

    foreach (vecs[i]) begin
      run_edges(vecs[i].edge_no - edges, "vec_model");
      check($sformatf("vec_edge%0d", vecs[i].edge_no), CLK_OUT, vecs[i].exp_out);
    end

    // Reset in the middle of the low phase, after edge 37.
    @(negedge CLK_IN);
    do_reset(HALF * 10, 0);
    run_edges(37, "pre_mid_reset");
    check("mid_low_before_reset", CLK_OUT, 1'b0);
    do_reset(200, 0);
    run_edges(24, "after_mid_reset");
    check("mid_reset_edge24_high", CLK_OUT, 1'b1);
    run_edges(1, "after_mid_reset");
    check("mid_reset_edge25_low", CLK_OUT, 1'b0);

    // Reset asserted coincident with a rising edge, then held across edges.
    @(posedge CLK_IN);
    n_RST = 1'b0;
    #1;
    check("rst_coincident", CLK_OUT, 1'b1);
    edges = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_IN);
      check("rst_coincident_held", CLK_OUT, 1'b1);
      if (i < 2) @(posedge CLK_IN);
    end
    #10;
    n_RST = 1'b1;
    run_edges(26, "after_held_reset");
    check("held_reset_edge26_low", CLK_OUT, 1'b0);

    // Ten full output periods: every phase exactly HALF cycles long.
    @(negedge CLK_IN);
    do_reset(100, 1);
    prev    = CLK_OUT;
    run_len = 1;
    for (int i = 0; i < 10 * DIV; i++) begin
      run_edges(1, "period_model");
      if (CLK_OUT === prev) begin
        run_len++;
      end else begin
        check($sformatf("phase_len_%0d_is_%0d", i, run_len), (run_len == HALF), 1'b1);
        prev    = CLK_OUT;
        run_len = 1;
      end
    end

    // Random mix of runs and asynchronous resets against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_reset($urandom_range(1, 450), $urandom_range(0, 3));
      else
        run_edges($urandom_range(1, 60), "random_model");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
